vicii_sprite_mux: RTL and testbench

Priority arbiter and collision detector for the eight vicii_sprite units. Each cycle it combines their pixel/pixel_enable outputs with the background graphics pixel and the border to produce the single VIC-II output colour. It also latches sprite-sprite and sprite-data collisions into clear-on-read registers and raises interrupt request pulses. It sits between the sprite units and graphics sequencer on one side and the colour/video output and register file on the other.

---
 rtl/vicii_sprite_mux.sv | 78 +++++++
 tb/tb_vicii_sprite_mux.sv | 144 ++++++++++++++
 2 files changed

// File: rtl/vicii_sprite_mux.sv
// VIC-II sprite priority multiplexer and collision detector.
// Picks the output colour from border, sprites and background, and latches clear-on-read collision flags.
module vicii_sprite_mux #(
   parameter int NSPR = 8
) (
   input  logic                clk,
   input  logic                reset,
   input  logic [NSPR-1:0]     spr_en,
   input  logic [4*NSPR-1:0]   spr_pix,
   input  logic [3:0]          bg_pix,
   input  logic                bg_fg,
   input  logic [NSPR-1:0]     mdp,
   input  logic                border,
   input  logic [3:0]          ec,
   input  logic                rd_mm,
   input  logic                rd_md,
   output logic [3:0]          pix_out,
   output logic [NSPR-1:0]     mm_col,
   output logic [NSPR-1:0]     md_col,
   output logic                irq_mm,
   output logic                irq_md
);

   logic                    win_found;
   logic [$clog2(NSPR)-1:0] win_idx;
   logic [3:0]              pix_next;
   logic [NSPR-1:0]         mm_new;
   logic [NSPR-1:0]         md_new;
   logic [NSPR-1:0]         mm_base;
   logic [NSPR-1:0]         md_base;
   logic                    multi_hit;

   always_comb begin
      win_found = 1'b0;
      win_idx   = '0;
      // Scan downward so the lowest-numbered enabled sprite is the last assignment and wins.
      for (int i = NSPR - 1; i >= 0; i--) begin
         if (spr_en[i]) begin
            win_found = 1'b1;
            win_idx   = i[$clog2(NSPR)-1:0];
         end
      end
   end

   always_comb begin
      pix_next = spr_pix[4*win_idx +: 4];
      if (border)
         pix_next = ec;
      else if (!win_found)
         pix_next = bg_pix;
      else if (mdp[win_idx] && bg_fg)
         pix_next = bg_pix;
   end

   // Clearing a power-of-two value leaves zero, so a non-zero result means two or more sprites overlap.
   assign multi_hit = (spr_en & (spr_en - 1'b1)) != '0;
   assign mm_new    = multi_hit ? spr_en : '0;
   assign md_new    = bg_fg ? spr_en : '0;
   assign mm_base   = rd_mm ? '0 : mm_col;
   assign md_base   = rd_md ? '0 : md_col;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         pix_out <= '0;
         mm_col  <= '0;
         md_col  <= '0;
         irq_mm  <= 1'b0;
         irq_md  <= 1'b0;
      end else begin
         pix_out <= pix_next;
         mm_col  <= mm_base | mm_new;
         md_col  <= md_base | md_new;
         irq_mm  <= (mm_base == '0) && (mm_new != '0);
         irq_md  <= (md_base == '0) && (md_new != '0);
      end
   end

endmodule

// File: tb/tb_vicii_sprite_mux.sv
// Directed self-checking bench for vicii_sprite_mux.
module tb_vicii_sprite_mux;

   logic        clk = 1'b0;
   logic        reset;
   logic [7:0]  spr_en;
   logic [31:0] spr_pix;
   logic [3:0]  bg_pix;
   logic        bg_fg;
   logic [7:0]  mdp;
   logic        border;
   logic [3:0]  ec;
   logic        rd_mm;
   logic        rd_md;
   logic [3:0]  pix_out;
   logic [7:0]  mm_col;
   logic [7:0]  md_col;
   logic        irq_mm;
   logic        irq_md;

   int checks = 0;
   int errors = 0;

   vicii_sprite_mux #(.NSPR(8)) dut (
      .clk(clk), .reset(reset), .spr_en(spr_en), .spr_pix(spr_pix),
      .bg_pix(bg_pix), .bg_fg(bg_fg), .mdp(mdp), .border(border), .ec(ec),
      .rd_mm(rd_mm), .rd_md(rd_md), .pix_out(pix_out), .mm_col(mm_col),
      .md_col(md_col), .irq_mm(irq_mm), .irq_md(irq_md)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      reset = 1'b0; spr_en = 8'h06; spr_pix = 32'h0000_0520; bg_pix = 4'd9;
      bg_fg = 1'b1; mdp = 8'h00; border = 1'b0; ec = 4'd1; rd_mm = 1'b0; rd_md = 1'b0;
      tick(); tick();
      check("rst_pix", {4'h0, pix_out}, 8'h00);
      check("rst_mm", mm_col, 8'h00);
      check("rst_md", md_col, 8'h00);
      check("rst_irq", {6'h0, irq_mm, irq_md}, 8'h00);
      $display("step reset held: pix=%0d mm=%h md=%h", pix_out, mm_col, md_col);

      spr_en = 8'h00; bg_fg = 1'b0; bg_pix = 4'd6;
      reset = 1'b1;
      tick();
      check("bg_pix", {4'h0, pix_out}, 8'h06);
      check("bg_mm", mm_col, 8'h00);
      $display("step background: pix=%0d", pix_out);

      spr_en = 8'h06; spr_pix = 32'h0000_0520;
      tick();
      check("ovl_pix", {4'h0, pix_out}, 8'h02);
      check("ovl_mm", mm_col, 8'h06);
      check("ovl_irq", {7'h0, irq_mm}, 8'h01);
      check("ovl_md", md_col, 8'h00);
      $display("step overlap: pix=%0d mm=%h irq_mm=%b", pix_out, mm_col, irq_mm);
      tick();
      check("ovl2_irq", {7'h0, irq_mm}, 8'h00);
      check("ovl2_mm", mm_col, 8'h06);
      $display("step overlap repeat: mm=%h irq_mm=%b", mm_col, irq_mm);

      spr_en = 8'h01; mdp = 8'h01; bg_fg = 1'b1; bg_pix = 4'd3; spr_pix = 32'h0000_0527;
      tick();
      check("pri_behind_pix", {4'h0, pix_out}, 8'h03);
      check("pri_md", md_col, 8'h01);
      check("pri_irq_md", {7'h0, irq_md}, 8'h01);
      $display("step behind fg: pix=%0d md=%h", pix_out, md_col);
      mdp = 8'h00;
      tick();
      check("pri_front_pix", {4'h0, pix_out}, 8'h07);
      check("pri_irq_md2", {7'h0, irq_md}, 8'h00);
      $display("step in front: pix=%0d", pix_out);
      border = 1'b1; ec = 4'd14;
      tick();
      check("border_pix", {4'h0, pix_out}, 8'h0E);
      check("border_md", md_col, 8'h01);
      $display("step border: pix=%0d md=%h", pix_out, md_col);
      border = 1'b0;

      spr_en = 8'h00; bg_fg = 1'b0; rd_mm = 1'b1;
      tick();
      check("clr_mm", mm_col, 8'h00);
      check("clr_irq", {7'h0, irq_mm}, 8'h00);
      check("clr_md_kept", md_col, 8'h01);
      $display("step read clear: mm=%h", mm_col);
      rd_mm = 1'b0; spr_en = 8'h06;
      tick();
      check("re_mm", mm_col, 8'h06);
      spr_en = 8'h81; rd_mm = 1'b1;
      tick();
      check("rdcol_mm", mm_col, 8'h81);
      check("rdcol_irq", {7'h0, irq_mm}, 8'h01);
      $display("step read during collision: mm=%h irq_mm=%b", mm_col, irq_mm);

      spr_en = 8'h00; rd_mm = 1'b1; rd_md = 1'b1;
      tick();
      rd_mm = 1'b0; rd_md = 1'b0; spr_en = 8'h03;
      tick();
      check("set_mm03", mm_col, 8'h03);
      spr_en = 8'h10; bg_fg = 1'b1;
      tick();
      check("set_md10", md_col, 8'h10);
      check("keep_mm03", mm_col, 8'h03);
      spr_en = 8'h00; bg_fg = 1'b0; rd_mm = 1'b1; rd_md = 1'b1;
      tick();
      check("both_mm", mm_col, 8'h00);
      check("both_md", md_col, 8'h00);
      check("both_irq", {6'h0, irq_mm, irq_md}, 8'h00);
      $display("step dual read: mm=%h md=%h", mm_col, md_col);
      rd_mm = 1'b0; rd_md = 1'b0;

      spr_en = 8'hFF; spr_pix = 32'h0000_0527;
      tick();
      check("all_mm", mm_col, 8'hFF);
      check("all_pix", {4'h0, pix_out}, 8'h07);
      spr_en = 8'h00;
      #2;
      reset = 1'b0;
      #1;
      check("async_mm", mm_col, 8'h00);
      check("async_pix", {4'h0, pix_out}, 8'h00);
      check("async_irq", {6'h0, irq_mm, irq_md}, 8'h00);
      $display("step async reset: mm=%h pix=%0d", mm_col, pix_out);
      reset = 1'b1;
      tick();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
